ins_fetch: RTL
==============

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter: TMO_CYC, default 15, maximum consecutive REQ cycles without mem_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_en  input  1  control-unit request to fetch the instruction at PC; sampled only in IDLE.
REQ-005 pc_ld  input  1  load PC from pc_in; sampled only in IDLE.
REQ-006 pc_in  input  16  jump/branch target address.
REQ-007 mem_req  output  1  instruction-memory read request.
REQ-008 mem_addr  output  16  instruction-memory read address.
REQ-009 mem_ack  input  1  memory read-data-valid strobe.
REQ-010 mem_rdata  input  16  memory read data; valid only when mem_ack=1.
REQ-011 ins_out  output  16  registered instruction word, driven to the IR ins_in input.
REQ-012 il_out  output  1  one-cycle IR load strobe, driven to the IR il_in input.
REQ-013 pc_out  output  16  current program counter.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, REQ, LOAD; the FSM SHALL power up and reset into IDLE.
REQ-017 IDLE: pc_ld=1 SHALL set PC<=pc_in and clear fetch_err on the next edge.
REQ-018 IDLE: fetch_en=1 SHALL move to REQ on the next edge, with mem_req=1 and mem_addr=PC, where PC is pc_in if pc_ld=1 in the same cycle.
REQ-019 REQ: mem_req SHALL stay 1 and mem_addr stable until mem_ack=1 or timeout.
REQ-020 REQ with mem_ack=1: ins_out<=mem_rdata; move to LOAD; mem_req=0 from the next cycle.
REQ-021 LOAD: il_out=1 for exactly one cycle with ins_out stable; PC<=PC+1 mod 2^16 (0xFFFF wraps to 0x0000); then IDLE.
REQ-022 Minimum fetch SHALL be 3 cycles (IDLE->REQ->LOAD->IDLE) with zero-wait memory, i.e. mem_ack in the first REQ cycle; il_out SHALL assert 2 cycles after fetch_en.
REQ-023 Timeout: an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without mem_ack; reaching TMO_CYC SHALL drop mem_req, set fetch_err, return to IDLE, leave PC and ins_out unchanged, and issue no il_out.
REQ-024 mem_ack in the cycle the counter reaches TMO_CYC SHALL win over timeout.
REQ-025 mem_ack outside REQ, and fetch_en or pc_ld outside IDLE, SHALL be ignored.
REQ-026 ins_out SHALL change only on accepted mem_ack; il_out SHALL never assert outside LOAD.
REQ-027 fetch_err SHALL stay set until pc_ld in IDLE or reset; fetch_en SHALL still be honoured while fetch_err=1.
REQ-028 busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, PC=0x0000, ins_out=0x0000, il_out=0, mem_req=0, mem_addr=0x0000, busy=0, fetch_err=0, timeout counter=0.
REQ-030 Reset asserted mid-fetch SHALL abort without il_out; the first fetch after release SHALL read address 0x0000.
REQ-031 After reset, no output SHALL carry X/Z while rst_n=1.

Verification
REQ-032 Reset, fetch_en pulse, mem_ack in the first REQ cycle with rdata 0x1234 -> mem_addr=0x0000, ins_out=0x1234, il_out a 1-cycle pulse 2 cycles after fetch_en, pc_out=0x0001.
REQ-033 pc_ld=1 with pc_in=0xFFFF, then fetch with 3 wait cycles, rdata 0xA5A5 -> mem_req high 4 cycles at 0xFFFF, ins_out=0xA5A5, pc_out wraps to 0x0000.
REQ-034 TMO_CYC=15, fetch with no mem_ack -> mem_req drops after 15 REQ cycles, fetch_err=1, no il_out, PC and ins_out unchanged; a later pc_ld clears fetch_err.
REQ-035 mem_ack exactly on the 15th REQ cycle -> normal LOAD and fetch_err stays 0.
REQ-036 pc_ld=1 with pc_in=0x0040 and fetch_en in the same IDLE cycle -> mem_addr=0x0040; pc_ld pulses during REQ and LOAD are ignored.
REQ-037 rst_n=0 during REQ with mem_ack arriving after -> no il_out, all outputs at reset values, next fetch reads 0x0000; bench checks IR-side property: ins_out constant whenever il_out=0.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch unit: reads the word at PC from instruction memory and
// hands it to the IR with a one-cycle load strobe; aborts on memory timeout.
module ins_fetch #(
    parameter int unsigned TMO_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        pc_ld,
    input  logic [15:0] pc_in,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ins_out,
    output logic        il_out,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LOAD = 2'd2
    } state_e;

    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ins_q, ins_d;
    logic        il_q, il_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc_s;
    logic        busy_s;

    // State and registered-output update; reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= 16'h0000;
            ins_q   <= 16'h0000;
            il_q    <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= 16'h0000;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            il_q    <= il_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        il_d      = 1'b0;
        req_d     = req_q;
        addr_d    = addr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        cnt_inc_s = cnt_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (pc_ld) begin
                    pc_d  = pc_in;
                    err_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
                // A same-cycle pc_ld redirects this very fetch to pc_in.
                if (fetch_en) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_ld ? pc_in : pc_q;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack) begin
                    ins_d   = mem_rdata;
                    il_d    = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_LOAD;
                end else if (cnt_inc_s == TMO_LIM) begin
                    cnt_d   = cnt_inc_s;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = S_REQ;
                end
            end
            S_LOAD: begin
                pc_d    = pc_q + 16'd1;
                state_d = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Status derived directly from the state register.
    always_comb begin
        busy_s = (state_q != S_IDLE);
    end

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign ins_out   = ins_q;
    assign il_out    = il_q;
    assign pc_out    = pc_q;
    assign busy      = busy_s;
    assign fetch_err = err_q;

endmodule
